// File: rtl/seat_request_queue.sv
// Two-kiosk seat request front-end: round-robin grant, validation, FIFO, gap-spaced write replay.
// Define SEAT_REQ_REJECT_CNT_EN to add the saturating reject_cnt output.
module seat_request_queue #(
    parameter int DEPTH = 4,
    parameter int SEATS = 8,
    parameter int GAP   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        k0_valid,
    output logic        k0_ready,
    input  logic [31:0] k0_student_no,
    input  logic [4:0]  k0_seat_no,
    input  logic [1:0]  k0_seat_state,
    input  logic        k1_valid,
    output logic        k1_ready,
    input  logic [31:0] k1_student_no,
    input  logic [4:0]  k1_seat_no,
    input  logic [1:0]  k1_seat_state,
    output logic        write,
    output logic [31:0] Student_No,
    output logic [4:0]  Seat_No,
    output logic [1:0]  Seat_State,
    output logic [4:0]  level,
    output logic        err
`ifdef SEAT_REQ_REJECT_CNT_EN
    ,
    output logic [7:0]  reject_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [4:0] LVL_MAX  = 5'(DEPTH);
    localparam logic [4:0] SEAT_MAX = 5'(SEATS);
    localparam logic [2:0] GAP_LOAD = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    typedef struct packed {
        logic [31:0] student;
        logic [4:0]  seat;
        logic [1:0]  state;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          req;
    entry_t          hold;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            rr;
    logic [1:0]      fsm;
    logic [2:0]      gap_cnt;
    logic            grant0;
    logic            grant1;
    logic            accept;
    logic            legal;
    logic            push;
    logic            reject;
    logic            pop_ok;
    logic            pop;

    always_comb begin
        grant0   = k0_valid && (!k1_valid || !rr);
        grant1   = k1_valid && (!k0_valid || rr);
        k0_ready = rst_n && (level < LVL_MAX) && grant0;
        k1_ready = rst_n && (level < LVL_MAX) && grant1;
        accept   = (k0_valid && k0_ready) || (k1_valid && k1_ready);

        req.student = grant0 ? k0_student_no : k1_student_no;
        req.seat    = grant0 ? k0_seat_no    : k1_seat_no;
        req.state   = grant0 ? k0_seat_state : k1_seat_state;

        legal  = (req.seat != 5'd0) && (req.seat <= SEAT_MAX) && (req.state != 2'd3);
        push   = accept && legal;
        reject = accept && !legal;
    end

    // The last GAP cycle may pop directly so pulses with a backlog land GAP+1 cycles apart.
    always_comb begin
        pop_ok = 1'b0;
        case (fsm)
            ST_IDLE:  pop_ok = 1'b1;
            ST_ISSUE: pop_ok = (GAP == 0);
            ST_GAP:   pop_ok = (gap_cnt == 3'd0);
            default:  pop_ok = 1'b0;
        endcase
        pop = pop_ok && (level != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= req;
        end
    end

    // The popped head waits in hold for one cycle and reaches the outputs together with write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= 5'd0;
            rr         <= 1'b0;
            fsm        <= ST_IDLE;
            gap_cnt    <= 3'd0;
            hold       <= '0;
            write      <= 1'b0;
            Student_No <= 32'd0;
            Seat_No    <= 5'd0;
            Seat_State <= 2'd0;
            err        <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                hold   <= mem[rd_ptr];
            end
            level <= level + {4'd0, push} - {4'd0, pop};
            rr    <= rr ^ (k0_valid && k1_valid);
            err   <= reject;
            write <= (fsm == ST_ISSUE);
            if (fsm == ST_ISSUE) begin
                {Student_No, Seat_No, Seat_State} <= hold;
            end

            case (fsm)
                ST_IDLE: begin
                    if (pop) begin
                        fsm <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (GAP > 0) begin
                        fsm     <= ST_GAP;
                        gap_cnt <= GAP_LOAD;
                    end else if (!pop) begin
                        fsm <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 3'd0) begin
                        fsm <= pop ? ST_ISSUE : ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 3'd1;
                    end
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

`ifdef SEAT_REQ_REJECT_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reject_cnt <= 8'd0;
        end else if (reject && (reject_cnt != 8'hFF)) begin
            reject_cnt <= reject_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seat_request_queue.sv
// Self-checking bench for seat_request_queue: three instances (GAP 1, 0, 3) share the kiosk
// stimulus and are checked against a queue/timestamp reference model.
module tb_seat_request_queue;

    localparam int DEPTH = 4;
    localparam int SEATS = 8;
    localparam int NDUT  = 3;

    typedef struct packed {
        logic [31:0] sn;
        logic [4:0]  seat;
        logic [1:0]  st;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        k0_valid, k1_valid;
    logic [31:0] k0_student_no, k1_student_no;
    logic [4:0]  k0_seat_no, k1_seat_no;
    logic [1:0]  k0_seat_state, k1_seat_state;

    logic [NDUT-1:0] k0_ready_v, k1_ready_v, write_v, err_v;
    logic [31:0]     sn_v    [NDUT];
    logic [4:0]      seat_v  [NDUT];
    logic [1:0]      st_v    [NDUT];
    logic [4:0]      level_v [NDUT];
`ifdef SEAT_REQ_REJECT_CNT_EN
    logic [7:0]      rej_v   [NDUT];
`endif

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int G = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        seat_request_queue #(.DEPTH(DEPTH), .SEATS(SEATS), .GAP(G)) dut (
            .clk(clk), .rst_n(rst_n),
            .k0_valid(k0_valid), .k0_ready(k0_ready_v[g]), .k0_student_no(k0_student_no),
            .k0_seat_no(k0_seat_no), .k0_seat_state(k0_seat_state),
            .k1_valid(k1_valid), .k1_ready(k1_ready_v[g]), .k1_student_no(k1_student_no),
            .k1_seat_no(k1_seat_no), .k1_seat_state(k1_seat_state),
            .write(write_v[g]), .Student_No(sn_v[g]), .Seat_No(seat_v[g]), .Seat_State(st_v[g]),
            .level(level_v[g]), .err(err_v[g])
`ifdef SEAT_REQ_REJECT_CNT_EN
            , .reject_cnt(rej_v[g])
`endif
        );
    end

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: per-instance request queue, pending pop and pop timestamps.
    req_t mq [NDUT][$];
    bit   m_pend_v [NDUT];
    req_t m_pend   [NDUT];
    bit   m_write  [NDUT];
    req_t m_out    [NDUT];
    bit   m_err    [NDUT];
    int   m_rej    [NDUT];
    int   m_last_pop [NDUT];
    bit   m_rr = 1'b0;
    int   m_cyc = 0;

    function automatic int gap_of(int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    function automatic bit exp_ready(int d, int k);
        bit g0 = k0_valid && (!k1_valid || !m_rr);
        bit g1 = k1_valid && (!k0_valid || m_rr);
        if (rst_n !== 1'b1) return 1'b0;
        if (mq[d].size() >= DEPTH) return 1'b0;
        return (k == 0) ? g0 : g1;
    endfunction

    task automatic model_edge();
        for (int d = 0; d < NDUT; d++) begin
            if (rst_n !== 1'b1) begin
                mq[d].delete();
                m_pend_v[d]   = 1'b0;
                m_pend[d]     = '0;
                m_write[d]    = 1'b0;
                m_out[d]      = '0;
                m_err[d]      = 1'b0;
                m_rej[d]      = 0;
                m_last_pop[d] = -100;
            end else begin
                bit   acc0, acc1, legal, do_pop;
                req_t r;
                acc0   = exp_ready(d, 0);
                acc1   = exp_ready(d, 1);
                r.sn   = acc0 ? k0_student_no : k1_student_no;
                r.seat = acc0 ? k0_seat_no : k1_seat_no;
                r.st   = acc0 ? k0_seat_state : k1_seat_state;
                legal  = (r.seat >= 5'd1) && (r.seat <= 5'(SEATS)) && (r.st != 2'd3);
                do_pop = (mq[d].size() > 0) && (m_cyc >= m_last_pop[d] + gap_of(d) + 1);
                m_write[d] = m_pend_v[d];
                if (m_pend_v[d]) m_out[d] = m_pend[d];
                m_pend_v[d] = do_pop;
                if (do_pop) begin
                    m_pend[d]     = mq[d].pop_front();
                    m_last_pop[d] = m_cyc;
                end
                if ((acc0 || acc1) && legal) mq[d].push_back(r);
                m_err[d] = (acc0 || acc1) && !legal;
                if (m_err[d] && (m_rej[d] < 255)) m_rej[d]++;
            end
        end
        if (rst_n !== 1'b1) m_rr = 1'b0;
        else if (k0_valid && k1_valid) m_rr = !m_rr;
        m_cyc++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_k0(bit v, int sn, int seat, int st);
        k0_valid = v; k0_student_no = 32'(sn); k0_seat_no = 5'(seat); k0_seat_state = 2'(st);
    endtask

    task automatic set_k1(bit v, int sn, int seat, int st);
        k1_valid = v; k1_student_no = 32'(sn); k1_seat_no = 5'(seat); k1_seat_state = 2'(st);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_k0(0, 0, 0, 0);
        set_k1(0, 0, 0, 0);
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_k0(1, 11, 3, 2);
        set_k1(1, 22, 4, 1);
        for (int c = 0; c < 2; c++) begin
            cycle();
            #1;
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (k0_ready_v[d] !== 1'b0 || k1_ready_v[d] !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL reset_ready dut%0d: got %b%b expected 00", d, k0_ready_v[d], k1_ready_v[d]);
                end
                checks++;
                if (write_v[d] !== 1'b0 || err_v[d] !== 1'b0 || level_v[d] !== 5'd0 ||
                    sn_v[d] !== 32'd0 || seat_v[d] !== 5'd0 || st_v[d] !== 2'd0) begin
                    errors++;
                    $display("[TB] FAIL reset_outputs dut%0d: got w=%b e=%b lvl=%0d f=%0d/%0d/%0d expected all 0",
                             d, write_v[d], err_v[d], level_v[d], sn_v[d], seat_v[d], st_v[d]);
                end
            end
        end
        rst_n = 1'b1;
        set_k0(0, 0, 0, 0);
        set_k1(0, 0, 0, 0);
    endtask

    task automatic test_single();
        set_k0(1, 201819186, 1, 2);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (k0_ready_v[d] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL single_ready dut%0d: got %b expected 1", d, k0_ready_v[d]);
            end
        end
        cycle();
        set_k0(0, 0, 0, 0);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (level_v[d] !== 5'd1) begin
                errors++;
                $display("[TB] FAIL single_level dut%0d: got %0d expected 1", d, level_v[d]);
            end
        end
        for (int t = 1; t <= 5; t++) begin
            cycle();
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (write_v[d] !== (t == 2)) begin
                    errors++;
                    $display("[TB] FAIL single_write dut%0d t%0d: got %b expected %b", d, t, write_v[d], t == 2);
                end
                if (t == 2) begin
                    checks++;
                    if (sn_v[d] !== 32'd201819186 || seat_v[d] !== 5'd1 || st_v[d] !== 2'd2) begin
                        errors++;
                        $display("[TB] FAIL single_fields dut%0d: got %0d/%0d/%0d expected 201819186/1/2",
                                 d, sn_v[d], seat_v[d], st_v[d]);
                    end
                end
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (level_v[d] !== 5'd0) begin
                errors++;
                $display("[TB] FAIL single_drain dut%0d: got %0d expected 0", d, level_v[d]);
            end
        end
    endtask

    task automatic test_contention();
        int got_sn[$];
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_k0(1, 1000 + i, (i % 8) + 1, i % 3);
            set_k1(1, 2000 + i, ((i + 3) % 8) + 1, (i + 1) % 3);
            #1;
            for (int d = 0; d < NDUT; d++) begin
                bit room = mq[d].size() < DEPTH;
                checks++;
                if (k0_ready_v[d] !== ((i % 2 == 0) && room) || k1_ready_v[d] !== ((i % 2 == 1) && room)) begin
                    errors++;
                    $display("[TB] FAIL contention_grant dut%0d i%0d: got %b%b expected %b%b", d, i,
                             k0_ready_v[d], k1_ready_v[d], (i % 2 == 0) && room, (i % 2 == 1) && room);
                end
            end
            cycle();
            if (write_v[1] === 1'b1) got_sn.push_back(int'(sn_v[1]));
        end
        set_k0(0, 0, 0, 0);
        set_k1(0, 0, 0, 0);
        for (int t = 0; t < 24; t++) begin
            cycle();
            if (write_v[1] === 1'b1) got_sn.push_back(int'(sn_v[1]));
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (write_v[d] !== m_write[d] || {sn_v[d], seat_v[d], st_v[d]} !== m_out[d]) begin
                    errors++;
                    $display("[TB] FAIL contention_drain dut%0d t%0d: got w=%b sn=%0d expected w=%b sn=%0d",
                             d, t, write_v[d], sn_v[d], m_write[d], m_out[d].sn);
                end
            end
        end
        checks++;
        if (got_sn.size() != 8) begin
            errors++;
            $display("[TB] FAIL contention_count: got %0d writes expected 8", got_sn.size());
        end
        for (int k = 0; k < got_sn.size() && k < 8; k++) begin
            int want = (k % 2 == 0) ? 1000 + k : 2000 + k;
            checks++;
            if (got_sn[k] != want) begin
                errors++;
                $display("[TB] FAIL contention_order k%0d: got %0d expected %0d", k, got_sn[k], want);
            end
        end
    endtask

    task automatic test_full();
        int blocked = 0;
        int peak = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_k0(1, 3000 + i, 2, 1);
            #1;
            checks++;
            if (k0_ready_v[2] !== exp_ready(2, 0)) begin
                errors++;
                $display("[TB] FAIL full_ready i%0d: got %b expected %b", i, k0_ready_v[2], exp_ready(2, 0));
            end
            if (k0_ready_v[2] === 1'b0) blocked++;
            if (int'(level_v[2]) > peak) peak = int'(level_v[2]);
            cycle();
            checks++;
            if (level_v[2] !== 5'(mq[2].size())) begin
                errors++;
                $display("[TB] FAIL full_level i%0d: got %0d expected %0d", i, level_v[2], mq[2].size());
            end
        end
        checks++;
        if (blocked == 0 || peak != 4) begin
            errors++;
            $display("[TB] FAIL full_backpressure: got blocked=%0d peak=%0d expected blocked>0 peak=4", blocked, peak);
        end
        set_k0(0, 0, 0, 0);
        for (int t = 0; t < 24; t++) cycle();
    endtask

    task automatic test_validation();
        int seats[4] = '{0, 9, 8, 3};
        int states[4] = '{1, 1, 0, 3};
        int errs[NDUT];
        int wrs[NDUT];
        do_reset();
        for (int d = 0; d < NDUT; d++) begin errs[d] = 0; wrs[d] = 0; end
        for (int t = 0; t < 12; t++) begin
            if (t < 4) set_k0(1, 7000 + t, seats[t], states[t]);
            else set_k0(0, 0, 0, 0);
            cycle();
            for (int d = 0; d < NDUT; d++) begin
                if (err_v[d] === 1'b1) errs[d]++;
                if (write_v[d] === 1'b1) wrs[d]++;
                checks++;
                if (err_v[d] !== m_err[d]) begin
                    errors++;
                    $display("[TB] FAIL validation_err dut%0d t%0d: got %b expected %b", d, t, err_v[d], m_err[d]);
                end
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (errs[d] != 3 || wrs[d] != 1) begin
                errors++;
                $display("[TB] FAIL validation_counts dut%0d: got err=%0d write=%0d expected err=3 write=1",
                         d, errs[d], wrs[d]);
            end
`ifdef SEAT_REQ_REJECT_CNT_EN
            checks++;
            if (rej_v[d] !== 8'd3) begin
                errors++;
                $display("[TB] FAIL validation_reject_cnt dut%0d: got %0d expected 3", d, rej_v[d]);
            end
`endif
        end
    endtask

    task automatic test_gap0_backlog();
        int wt[$];
        int ws[$];
        do_reset();
        for (int t = 0; t < 12; t++) begin
            if (t < 3) set_k0(1, 4000 + t, t + 1, t);
            else set_k0(0, 0, 0, 0);
            cycle();
            if (write_v[1] === 1'b1) begin
                wt.push_back(t);
                ws.push_back(int'(sn_v[1]));
            end
        end
        checks++;
        if (ws.size() != 3) begin
            errors++;
            $display("[TB] FAIL gap0_count: got %0d writes expected 3", ws.size());
        end
        for (int k = 0; k < ws.size() && k < 3; k++) begin
            checks++;
            if (ws[k] != 4000 + k || wt[k] != wt[0] + k) begin
                errors++;
                $display("[TB] FAIL gap0_seq k%0d: got sn=%0d at t%0d expected sn=%0d at t%0d",
                         k, ws[k], wt[k], 4000 + k, wt[0] + k);
            end
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_k0(1, 5000 + i, 2, 2);
            cycle();
        end
        set_k0(0, 0, 0, 0);
        checks++;
        if (level_v[2] !== 5'd3) begin
            errors++;
            $display("[TB] FAIL midop_prelevel: got %0d expected 3", level_v[2]);
        end
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (level_v[d] !== 5'd0 || write_v[d] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midop_reset dut%0d: got lvl=%0d w=%b expected 0/0", d, level_v[d], write_v[d]);
            end
        end
        for (int t = 0; t < 10; t++) begin
            cycle();
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (write_v[d] !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL midop_quiet dut%0d t%0d: got w=1 expected 0", d, t);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 400; t++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            set_k0($urandom_range(0, 9) < 7, int'($urandom), $urandom_range(0, 10), $urandom_range(0, 3));
            set_k1($urandom_range(0, 9) < 6, int'($urandom), $urandom_range(0, 10), $urandom_range(0, 3));
            #1;
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (k0_ready_v[d] !== exp_ready(d, 0) || k1_ready_v[d] !== exp_ready(d, 1)) begin
                    errors++;
                    $display("[TB] FAIL random_ready dut%0d t%0d: got %b%b expected %b%b", d, t,
                             k0_ready_v[d], k1_ready_v[d], exp_ready(d, 0), exp_ready(d, 1));
                end
            end
            cycle();
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (write_v[d] !== m_write[d] || {sn_v[d], seat_v[d], st_v[d]} !== m_out[d] ||
                    level_v[d] !== 5'(mq[d].size()) || err_v[d] !== m_err[d]) begin
                    errors++;
                    $display("[TB] FAIL random_outputs dut%0d t%0d: got w=%b f=%0d/%0d/%0d lvl=%0d e=%b expected w=%b f=%0d/%0d/%0d lvl=%0d e=%b",
                             d, t, write_v[d], sn_v[d], seat_v[d], st_v[d], level_v[d], err_v[d],
                             m_write[d], m_out[d].sn, m_out[d].seat, m_out[d].st, mq[d].size(), m_err[d]);
                end
`ifdef SEAT_REQ_REJECT_CNT_EN
                checks++;
                if (rej_v[d] !== 8'(m_rej[d])) begin
                    errors++;
                    $display("[TB] FAIL random_reject_cnt dut%0d t%0d: got %0d expected %0d", d, t, rej_v[d], m_rej[d]);
                end
`endif
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_full();
        test_validation();
        test_gap0_backlog();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
